// File: rtl/cp0_unit.sv
// Coprocessor-0 register file: Count/Compare timer, Status/Cause, EPC/BadVAddr, exception and ERET commit.
// Latency: register updates on the next clk edge; rdata, int_req and redirect are combinational from registers and inputs.
// Backpressure: none; a write, exception or ERET is accepted in every cycle it is presented.
module cp0_unit #(
    parameter int          HW_INT_N   = 6,
    parameter int          COUNT_DIV  = 2,
    parameter int          TIMER_LINE = 5,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
    parameter logic [31:0] PRID_VAL   = 32'h004C0102
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [4:0]          waddr,
    input  logic [31:0]         wdata,
    input  logic [4:0]          raddr,
    output logic [31:0]         rdata,
    input  logic [HW_INT_N-1:0] hw_int,
    input  logic                exc_valid,
    input  logic [4:0]          exc_code,
    input  logic [31:0]         exc_pc,
    input  logic                exc_bd,
    input  logic [31:0]         exc_badvaddr,
    input  logic                eret,
    output logic                int_req,
    output logic                redirect,
    output logic [31:0]         redirect_pc,
    output logic [31:0]         status,
    output logic [31:0]         cause,
    output logic [31:0]         epc,
    output logic [31:0]         count,
    output logic [31:0]         compare,
    output logic                timer_int
);

    localparam logic [4:0]  REG_BADVADDR = 5'd8;
    localparam logic [4:0]  REG_COUNT    = 5'd9;
    localparam logic [4:0]  REG_COMPARE  = 5'd11;
    localparam logic [4:0]  REG_STATUS   = 5'd12;
    localparam logic [4:0]  REG_CAUSE    = 5'd13;
    localparam logic [4:0]  REG_EPC      = 5'd14;
    localparam logic [4:0]  REG_PRID     = 5'd15;
    localparam logic [4:0]  REG_CONFIG   = 5'd16;
    localparam logic [31:0] CONFIG_VAL   = 32'h00008000;
    localparam logic [1:0]  PRESC_LAST   = 2'(COUNT_DIV - 1);

    logic [31:0] count_q;
    logic [31:0] compare_q;
    logic [31:0] epc_q;
    logic [31:0] badvaddr_q;
    logic [1:0]  presc_q;
    logic [7:0]  im_q;
    logic        exl_q;
    logic        ie_q;
    logic [5:0]  ip_hw_q;
    logic [1:0]  ip_sw_q;
    logic        ti_q;
    logic        bd_q;
    logic [4:0]  exc_code_q;

    logic        wr_count;
    logic        wr_compare;
    logic        wr_status;
    logic        wr_cause;
    logic        wr_epc;
    logic        timer_match;
    logic        epc_capture;
    logic [5:0]  hw_ext;
    logic [5:0]  ti_line;
    logic [7:0]  ip_all;
    logic [31:0] status_val;
    logic [31:0] cause_val;

    assign wr_count    = we && (waddr == REG_COUNT);
    assign wr_compare  = we && (waddr == REG_COMPARE);
    assign wr_status   = we && (waddr == REG_STATUS);
    assign wr_cause    = we && (waddr == REG_CAUSE);
    assign wr_epc      = we && (waddr == REG_EPC);
    assign timer_match = (count_q == compare_q) && (compare_q != 32'd0);
    // EPC and BD are only captured for the outermost exception.
    assign epc_capture = exc_valid && !exl_q;
    assign hw_ext      = 6'(hw_int);

    // Count with prescaler; an MTC0 to Count restarts the prescaler phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= 32'd0;
            presc_q <= 2'd0;
        end else if (wr_count) begin
            count_q <= wdata;
            presc_q <= 2'd0;
        end else if (presc_q == PRESC_LAST) begin
            count_q <= count_q + 32'd1;
            presc_q <= 2'd0;
        end else begin
            presc_q <= presc_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            compare_q <= 32'd0;
            ti_q      <= 1'b0;
        end else begin
            if (wr_compare) begin
                compare_q <= wdata;
            end
            if (wr_compare) begin
                ti_q <= 1'b0;
            end else if (timer_match) begin
                ti_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            im_q    <= 8'd0;
            ie_q    <= 1'b0;
            exl_q   <= 1'b0;
            ip_hw_q <= 6'd0;
            ip_sw_q <= 2'd0;
        end else begin
            ip_hw_q <= hw_ext;
            if (wr_cause) begin
                ip_sw_q <= wdata[9:8];
            end
            if (wr_status) begin
                im_q <= wdata[15:8];
                ie_q <= wdata[0];
            end
            if (exc_valid) begin
                exl_q <= 1'b1;
            end else if (eret) begin
                exl_q <= 1'b0;
            end else if (wr_status) begin
                exl_q <= wdata[1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            epc_q      <= 32'd0;
            bd_q       <= 1'b0;
            exc_code_q <= 5'd0;
            badvaddr_q <= 32'd0;
        end else begin
            if (exc_valid) begin
                exc_code_q <= exc_code;
            end
            if (epc_capture) begin
                epc_q <= exc_bd ? (exc_pc - 32'd4) : exc_pc;
                bd_q  <= exc_bd;
            end else if (wr_epc) begin
                epc_q <= wdata;
            end
            if (exc_valid && ((exc_code == 5'd4) || (exc_code == 5'd5))) begin
                badvaddr_q <= exc_badvaddr;
            end
        end
    end

    always_comb begin
        ti_line             = 6'd0;
        ti_line[TIMER_LINE] = ti_q;
    end

    assign ip_all     = {ip_hw_q | ti_line, ip_sw_q};
    assign status_val = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
    assign cause_val  = {bd_q, ti_q, 14'd0, ip_all, 1'b0, exc_code_q, 2'd0};

    always_comb begin
        rdata = 32'd0;
        case (raddr)
            REG_BADVADDR: rdata = badvaddr_q;
            REG_COUNT:    rdata = count_q;
            REG_COMPARE:  rdata = compare_q;
            REG_STATUS:   rdata = status_val;
            REG_CAUSE:    rdata = cause_val;
            REG_EPC:      rdata = epc_q;
            REG_PRID:     rdata = PRID_VAL;
            REG_CONFIG:   rdata = CONFIG_VAL;
            default:      rdata = 32'd0;
        endcase
    end

    assign int_req     = ie_q && !exl_q && (|(ip_all & im_q));
    assign redirect    = exc_valid || eret;
    assign redirect_pc = exc_valid ? EXC_VECTOR : epc_q;
    assign status      = status_val;
    assign cause       = cause_val;
    assign epc         = epc_q;
    assign count       = count_q;
    assign compare     = compare_q;
    assign timer_int   = ti_q;

endmodule

// File: tb/tb_cp0_unit.sv
// Bench for cp0_unit: word-level reference model checked every cycle, plus directed literal checks.
module tb_cp0_unit;

    localparam int          HW_INT_N   = 6;
    localparam int          COUNT_DIV  = 2;
    localparam int          TIMER_LINE = 5;
    localparam logic [31:0] EXC_VECTOR = 32'hBFC00380;
    localparam logic [31:0] PRID_VAL   = 32'h004C0102;

    logic                clk;
    logic                rst_n;
    logic                we;
    logic [4:0]          waddr;
    logic [31:0]         wdata;
    logic [4:0]          raddr;
    logic [31:0]         rdata;
    logic [HW_INT_N-1:0] hw_int;
    logic                exc_valid;
    logic [4:0]          exc_code;
    logic [31:0]         exc_pc;
    logic                exc_bd;
    logic [31:0]         exc_badvaddr;
    logic                eret;
    logic                int_req;
    logic                redirect;
    logic [31:0]         redirect_pc;
    logic [31:0]         status;
    logic [31:0]         cause;
    logic [31:0]         epc;
    logic [31:0]         count;
    logic [31:0]         compare;
    logic                timer_int;

    cp0_unit #(
        .HW_INT_N   (HW_INT_N),
        .COUNT_DIV  (COUNT_DIV),
        .TIMER_LINE (TIMER_LINE),
        .EXC_VECTOR (EXC_VECTOR),
        .PRID_VAL   (PRID_VAL)
    ) dut (
        .clk          (clk),
        .rst          (rst_n),
        .we           (we),
        .waddr        (waddr),
        .wdata        (wdata),
        .raddr        (raddr),
        .rdata        (rdata),
        .hw_int       (hw_int),
        .exc_valid    (exc_valid),
        .exc_code     (exc_code),
        .exc_pc       (exc_pc),
        .exc_bd       (exc_bd),
        .exc_badvaddr (exc_badvaddr),
        .eret         (eret),
        .int_req      (int_req),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .status       (status),
        .cause        (cause),
        .epc          (epc),
        .count        (count),
        .compare      (compare),
        .timer_int    (timer_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Reference model: architectural state as plain words and counters.
    logic [31:0] m_count, m_compare, m_epc, m_bva;
    int          m_ticks;
    logic [7:0]  m_im;
    logic        m_exl, m_ie, m_ti, m_bd;
    logic [5:0]  m_hw;
    logic [1:0]  m_sw;
    logic [4:0]  m_code;
    logic        mo_exl, mo_match;

    function automatic logic [7:0] m_ip();
        logic [7:0] ip;
        ip = {m_hw, m_sw};
        if (m_ti) ip[2+TIMER_LINE] = 1'b1;
        return ip;
    endfunction

    function automatic logic [31:0] m_status_w();
        return 32'h00400000 | (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
    endfunction

    function automatic logic [31:0] m_cause_w();
        return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_ip()) << 8) | (32'(m_code) << 2);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_bva;
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status_w();
            5'd13:   return m_cause_w();
            5'd14:   return m_epc;
            5'd15:   return PRID_VAL;
            5'd16:   return 32'h00008000;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_count = 0; m_ticks = 0; m_compare = 0; m_epc = 0; m_bva = 0;
            m_im = 0; m_exl = 0; m_ie = 0; m_ti = 0; m_bd = 0;
            m_hw = 0; m_sw = 0; m_code = 0;
        end else begin
            mo_exl   = m_exl;
            mo_match = (m_count == m_compare) && (m_compare != 0);
            if (we && waddr == 5'd9) begin
                m_count = wdata;
                m_ticks = 0;
            end else begin
                m_ticks = (m_ticks + 1) % COUNT_DIV;
                if (m_ticks == 0) m_count = m_count + 1;
            end
            if (we && waddr == 5'd11) begin
                m_compare = wdata;
                m_ti = 0;
            end else if (mo_match) begin
                m_ti = 1;
            end
            m_hw = 6'(hw_int);
            if (we && waddr == 5'd13) m_sw = wdata[9:8];
            if (we && waddr == 5'd12) begin
                m_im = wdata[15:8]; m_exl = wdata[1]; m_ie = wdata[0];
            end
            if (we && waddr == 5'd14) m_epc = wdata;
            // Commit effects applied last so they override a same-cycle MTC0.
            if (exc_valid) begin
                m_code = exc_code;
                if (!mo_exl) begin
                    m_epc = exc_bd ? exc_pc - 32'd4 : exc_pc;
                    m_bd  = exc_bd;
                end
                if (exc_code == 5'd4 || exc_code == 5'd5) m_bva = exc_badvaddr;
                m_exl = 1;
            end else if (eret) begin
                m_exl = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rdata", rdata, m_read(raddr));
            chk("status", status, m_status_w());
            chk("cause", cause, m_cause_w());
            chk("epc", epc, m_epc);
            chk("count", count, m_count);
            chk("compare", compare, m_compare);
            chk("timer_int", 32'(timer_int), 32'(m_ti));
            chk("int_req", 32'(int_req), 32'(m_ie && !m_exl && ((m_ip() & m_im) != 0)));
            chk("redirect", 32'(redirect), 32'(exc_valid || eret));
            chk("redirect_pc", redirect_pc, exc_valid ? EXC_VECTOR : m_epc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    task automatic peek(input logic [4:0] a, input string name, input logic [31:0] exp);
        raddr = a;
        #1;
        chk(name, rdata, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; we = 1'b0; waddr = 0; wdata = 0; raddr = 0; hw_int = 0;
        exc_valid = 0; exc_code = 0; exc_pc = 0; exc_bd = 0; exc_badvaddr = 0; eret = 0;
        tick();
        chk_en = 1'b1;

        // Reset state
        peek(5'd12, "rst_status", 32'h00400000);
        peek(5'd16, "rst_config", 32'h00008000);
        peek(5'd15, "rst_prid", PRID_VAL);
        tick();
        peek(5'd9,  "rst_count", 32'd0);
        peek(5'd11, "rst_compare", 32'd0);
        peek(5'd13, "rst_cause", 32'd0);
        tick();
        peek(5'd14, "rst_epc", 32'd0);
        peek(5'd8,  "rst_badvaddr", 32'd0);
        peek(5'd3,  "rst_unmapped", 32'd0);
        chk("rst_int_req", 32'(int_req), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Count wrap and timer
        mtc0(5'd9, 32'hFFFFFFFE);
        peek(5'd9, "cnt_load", 32'hFFFFFFFE);
        mtc0(5'd11, 32'h00000001);
        tick(); tick(); tick();
        peek(5'd9, "cnt_wrap", 32'h00000000);
        tick(); tick();
        chk("cnt_one", count, 32'h00000001);
        chk("ti_not_yet", 32'(timer_int), 32'd0);
        tick();
        chk("ti_set", 32'(timer_int), 32'd1);
        peek(5'd13, "cause_ti", 32'h40008000);
        mtc0(5'd11, 32'h80000000);
        chk("ti_clear", 32'(timer_int), 32'd0);

        // Hardware interrupt
        mtc0(5'd12, 32'h0000FF01);
        peek(5'd12, "status_wr", 32'h0040FF01);
        hw_int = 6'b000001;
        #1;
        chk("int_latency", 32'(int_req), 32'd0);
        tick();
        peek(5'd13, "cause_ip2", 32'h00000400);
        chk("int_req_on", 32'(int_req), 32'd1);

        // Address-error exception in a delay slot
        exc_valid = 1; exc_code = 5'd4; exc_pc = 32'h80001004; exc_bd = 1; exc_badvaddr = 32'h80002001;
        #1;
        chk("exc_redirect", 32'(redirect), 32'd1);
        chk("exc_vector", redirect_pc, 32'hBFC00380);
        tick();
        exc_valid = 0; exc_bd = 0;
        peek(5'd14, "exc_epc", 32'h80001000);
        peek(5'd13, "exc_cause", 32'h80000410);
        peek(5'd8,  "exc_bva", 32'h80002001);
        chk("exc_exl", status, 32'h0040FF03);
        chk("exc_int_drop", 32'(int_req), 32'd0);

        // Nested syscall keeps EPC/BD
        exc_valid = 1; exc_code = 5'd8; exc_pc = 32'h80003000; exc_badvaddr = 32'h12121212;
        tick();
        exc_valid = 0;
        peek(5'd14, "nest_epc", 32'h80001000);
        peek(5'd13, "nest_cause", 32'h80000420);
        peek(5'd8,  "nest_bva", 32'h80002001);
        eret = 1;
        #1;
        chk("eret_pc", redirect_pc, 32'h80001000);
        tick();
        eret = 0;
        chk("eret_exl", status, 32'h0040FF01);
        chk("eret_int", 32'(int_req), 32'd1);

        // Exception + ERET + MTC0 EPC in one cycle
        exc_valid = 1; exc_code = 5'd12; exc_pc = 32'h80004000; eret = 1;
        we = 1; waddr = 5'd14; wdata = 32'h12345678; raddr = 5'd14;
        #1;
        chk("nobypass", rdata, 32'h80001000);
        chk("prio_vector", redirect_pc, 32'hBFC00380);
        tick();
        exc_valid = 0; eret = 0; we = 0;
        chk("prio_epc", epc, 32'h80004000);
        chk("prio_exl", status, 32'h0040FF03);

        // Software IP bits only
        mtc0(5'd13, 32'hFFFFFFFF);
        peek(5'd13, "cause_sw", 32'h00000730);
        eret = 1;
        tick();
        eret = 0;
        chk("sw_int", 32'(int_req), 32'd1);

        // Asynchronous reset with a pending TI
        mtc0(5'd11, 32'd5);
        mtc0(5'd9, 32'd5);
        tick();
        chk("ti_pending", 32'(timer_int), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_ti", 32'(timer_int), 32'd0);
        chk("arst_count", count, 32'd0);
        chk("arst_status", status, 32'h00400000);
        chk("arst_epc", epc, 32'd0);
        peek(5'd8, "arst_bva", 32'd0);
        tick();
        rst_n = 1'b1;
        tick(); tick(); tick();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cp0_unit.md
# cp0_unit

Parametrised coprocessor-0 unit for the MIPS core: holds Count/Compare/Status/Cause/EPC/BadVAddr/PRId/Config, raises a masked interrupt request to the pipeline, and commits exceptions and ERET from the memory/writeback boundary. It supersedes the fixed CP0 register file. It adds a configurable hardware-interrupt count, a configurable Count prescaler and a computed exception target. It also adds MIPS-correct EXL nesting, where a nested exception does not overwrite EPC.

## Interface
Parameters:
- HW_INT_N, 6: number of hardware interrupt lines (1..6), mapped to Cause.IP[2+i]
- COUNT_DIV, 2: Count increments once per COUNT_DIV clocks (1, 2 or 4)
- TIMER_LINE, 5: hardware line index (0..5) the timer interrupt is ORed into
- EXC_VECTOR, 32'hBFC00380: general exception target
- PRID_VAL, 32'h004C0102: PRId read value

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- we  in  1  MTC0 write enable
- waddr  in  5  write register number
- wdata  in  32  write data
- raddr  in  5  read register number
- rdata  out  32  combinational read data
- hw_int  in  HW_INT_N  level hardware interrupts
- exc_valid  in  1  exception commit this cycle
- exc_code  in  5  ExcCode (0 Int, 4 AdEL, 5 AdES, 8 Sys, 9 Bp, 10 RI, 12 Ov)
- exc_pc  in  32  PC of faulting instruction
- exc_bd  in  1  faulting instruction is in a delay slot
- exc_badvaddr  in  32  faulting address
- eret  in  1  ERET commit this cycle
- int_req  out  1  interrupt pending and enabled
- redirect  out  1  exc_valid | eret
- redirect_pc  out  32  EXC_VECTOR if exc_valid, else EPC
- status, cause, epc, count, compare  out  32 each  register mirrors
- timer_int  out  1  Cause.TI

## Operation
- Register numbers: BadVAddr 8, Count 9, Compare 11, Status 12, Cause 13, EPC 14, PRId 15, Config 16. Reads of other numbers return 0.
- Status:
  - Writable bits are IM[15:8], EXL[1] and IE[0].
  - BEV[22] is read-only 1. All other bits read 0.
- Cause:
  - Writable bits are IP[9:8] only.
  - IP[7:2] are loaded each clock from hw_int. Bit 2+TIMER_LINE additionally ORs TI. Unused lines read 0.
  - TI is bit 30, BD is bit 31, ExcCode is bits [6:2].
- Count:
  - A prescaler counts 0..COUNT_DIV-1; Count increments when the prescaler wraps.
  - Count is 32-bit and wraps from FFFFFFFF to 00000000.
  - An MTC0 to Count loads wdata and resets the prescaler to 0; the write wins over an increment in the same cycle.
- Timer:
  - TI sets when Count == Compare and Compare != 0. TI is sticky.
  - An MTC0 to Compare clears TI. Clear wins if a match occurs in the same cycle.
- int_req = Status.IE & ~Status.EXL & |(Cause.IP[7:0] & Status.IM[7:0]). It is combinational from registers.
- Exception commit (exc_valid):
  - Cause.ExcCode <= exc_code.
  - If Status.EXL == 0: EPC <= exc_bd ? exc_pc-4 : exc_pc, and Cause.BD <= exc_bd.
  - If Status.EXL == 1: EPC and BD are unchanged.
  - Status.EXL <= 1.
  - BadVAddr <= exc_badvaddr only for codes 4 and 5.
- ERET: Status.EXL <= 0.
- Priority:
  - exc_valid beats eret; an ERET in the same cycle is ignored.
  - Exception updates to EXL/EPC/Cause beat an MTC0 to the same register in the same cycle. Other fields written by that MTC0 still take effect.
- Reset values:
  - Count 0, prescaler 0, Compare 0, Status 32'h00400000, Cause 0, EPC 0, BadVAddr 0.
  - Config 32'h00008000, TI 0.
  - int_req, redirect and rdata are driven by the reset register state (rdata reflects raddr).

## Timing
- All register updates happen on the rising clk edge. rst asserts asynchronously and deasserts synchronously to clk at the first rising edge.
- rdata is combinational with no write bypass: a read in the same cycle as an MTC0 to that register returns the old value, and the new value is visible from the next cycle.
- hw_int to Cause.IP to int_req: 1 clock latency.
- Count==Compare to TI to int_req: 1 clock after the match cycle.
- redirect and redirect_pc are combinational in the commit cycle; EPC is updated at the end of that cycle.
- Reset mid-operation: all state returns to reset values immediately; a pending TI is lost.

## Test plan
- Reset, then read all registers:
  - Status = 00400000, Config = 00008000, PRId = PRID_VAL, others 0.
  - int_req = 0.
- COUNT_DIV=2:
  - MTC0 Count=FFFFFFFE, Compare=00000001: Count reaches 00000000 after 4 clocks.
  - TI = 1 one clock after Count = 00000001.
  - MTC0 Compare clears TI.
- Status = 0000FF01, hw_int[0] = 1: Cause.IP2 = 1 and int_req = 1 after 1 clock. Setting EXL via an exception drops int_req.
- exc_valid, code 4, exc_pc 80001004, exc_bd = 1, badvaddr 80002001:
  - EPC = 80001000, BD = 1, ExcCode = 4, BadVAddr = 80002001, EXL = 1.
  - redirect_pc = EXC_VECTOR.
- Nested exception with EXL = 1 (code 8, pc 80003000): EPC unchanged, ExcCode = 8. A following eret sets redirect_pc = EPC and clears EXL.
- Same cycle exc_valid + eret + MTC0 EPC = 12345678: EPC takes the exception value and EXL = 1. Asserting rst mid-run clears everything asynchronously.
